// File: rtl/eth_regs_pkg.sv
// Shared definitions for the eth_top AXI4-Lite register file: response codes,
// register-map word offsets and the write-collector state encoding.
package eth_regs_pkg;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_COLLECT = 2'd1,
        WR_RESP    = 2'd2
    } wr_state_t;

    // First status register sits directly after the control block.
    function automatic int stat_base_idx(input int n_ctrl);
        return n_ctrl;
    endfunction

    function automatic int irq_status_idx(input int n_ctrl, input int n_stat);
        return n_ctrl + n_stat;
    endfunction

    function automatic int irq_enable_idx(input int n_ctrl, input int n_stat);
        return n_ctrl + n_stat + 1;
    endfunction

    // Expand four byte enables into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/eth_axil_wr_collect.sv
// AXI4-Lite write-side collector: holds AW and W independently, presents a
// single-cycle commit to the register storage and drives the B channel.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   WR_IDLE    | nothing held, both AW and W may handshake
//   WR_COLLECT | exactly one of address / data held, waiting for the other
//   WR_RESP    | write committed, bvalid high until bready
module eth_axil_wr_collect #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    output logic              cm_valid,
    output logic [ADDR_W-3:0] cm_idx,
    output logic [31:0]       cm_data,
    output logic [3:0]        cm_strb,
    input  logic              cm_err
);
    import eth_regs_pkg::*;

    wr_state_t         state;
    logic              aw_held;
    logic              w_held;
    logic [ADDR_W-3:0] aw_idx_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic              aw_hs;
    logic              w_hs;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^awaddr[1:0];

    assign awready = enable && !aw_held && !bvalid;
    assign wready  = enable && !w_held && !bvalid;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    // A commit fires on the edge where the second half arrives, using the
    // live bus value for whichever half is handshaking right now.
    assign cm_valid = (aw_held || aw_hs) && (w_held || w_hs);
    assign cm_idx   = aw_held ? aw_idx_q : awaddr[ADDR_W-1:2];
    assign cm_data  = w_held ? w_data_q : wdata;
    assign cm_strb  = w_held ? w_strb_q : wstrb;

    // Holding registers, commit sequencing and B-channel response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WR_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid   <= 1'b0;
            bresp    <= BRESP_OKAY;
        end else begin
            case (state)
                WR_IDLE, WR_COLLECT: begin
                    if (cm_valid) begin
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        bvalid  <= 1'b1;
                        bresp   <= cm_err ? BRESP_SLVERR : BRESP_OKAY;
                        state   <= WR_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_held  <= 1'b1;
                            aw_idx_q <= awaddr[ADDR_W-1:2];
                        end
                        if (w_hs) begin
                            w_held   <= 1'b1;
                            w_data_q <= wdata;
                            w_strb_q <= wstrb;
                        end
                        state <= (aw_held || aw_hs || w_held || w_hs) ? WR_COLLECT : WR_IDLE;
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= WR_IDLE;
                    end
                end
                default: state <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/eth_axil_regfile.sv
// AXI4-Lite slave register file for eth_top: control registers, sampled
// status inputs, sticky W1C interrupt status with enable mask and a level Irq.
module eth_axil_regfile #(
    parameter int ADDR_W = 12,
    parameter int N_CTRL = 4,
    parameter int N_STAT = 4,
    parameter int N_IRQ  = 8
) (
    input  logic                AXI_Clk,
    input  logic                AXI_Rstn,
    input  logic                AXI_awvalid,
    output logic                AXI_awready,
    input  logic [ADDR_W-1:0]   AXI_awaddr,
    input  logic                AXI_wvalid,
    output logic                AXI_wready,
    input  logic [31:0]         AXI_wdata,
    input  logic [3:0]          AXI_wstrb,
    output logic                AXI_bvalid,
    input  logic                AXI_bready,
    output logic [1:0]          AXI_bresp,
    input  logic                AXI_arvalid,
    output logic                AXI_arready,
    input  logic [ADDR_W-1:0]   AXI_araddr,
    output logic                AXI_rvalid,
    input  logic                AXI_rready,
    output logic [31:0]         AXI_rdata,
    output logic [1:0]          AXI_rresp,
    output logic [32*N_CTRL-1:0] Ctrl_Regs,
    output logic [N_CTRL-1:0]   Ctrl_Wr_Pulse,
    input  logic [32*N_STAT-1:0] Stat_Regs,
    input  logic [N_IRQ-1:0]    Irq_Events,
    output logic                Irq
);
    import eth_regs_pkg::*;

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0] STAT_LO = IDX_W'(stat_base_idx(N_CTRL));
    localparam logic [IDX_W-1:0] IRQ_ST  = IDX_W'(irq_status_idx(N_CTRL, N_STAT));
    localparam logic [IDX_W-1:0] IRQ_EN  = IDX_W'(irq_enable_idx(N_CTRL, N_STAT));

    if (N_CTRL + N_STAT + 2 > (1 << IDX_W)) begin : g_map_check
        $error("eth_axil_regfile: register map does not fit in ADDR_W");
    end
    if (N_IRQ < 1 || N_IRQ > 32) begin : g_irq_check
        $error("eth_axil_regfile: N_IRQ must be 1..32");
    end

    logic              live;
    logic              cm_valid;
    logic [IDX_W-1:0]  cm_idx;
    logic [31:0]       cm_data;
    logic [3:0]        cm_strb;
    logic              cm_err;
    logic [31:0]       cm_mask;
    logic [N_CTRL-1:0] pulse_d;
    logic [N_IRQ-1:0]  irq_clr;
    logic [31:0]       ctrl_q [N_CTRL];
    logic [N_IRQ-1:0]  irq_stat_q;
    logic [N_IRQ-1:0]  irq_en_q;
    logic [31:0]       irq_stat_w;
    logic [31:0]       irq_en_w;
    logic [IDX_W-1:0]  ar_idx;
    logic [31:0]       rd_data;
    logic              rd_err;
    logic              unused_ar_bits;

    assign unused_ar_bits = ^AXI_araddr[1:0];

    // Ready outputs stay low until the first clock after reset release.
    always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
        if (!AXI_Rstn) live <= 1'b0;
        else           live <= 1'b1;
    end

    eth_axil_wr_collect #(.ADDR_W(ADDR_W)) u_wr (
        .clk      (AXI_Clk),
        .rst_n    (AXI_Rstn),
        .enable   (live),
        .awvalid  (AXI_awvalid),
        .awready  (AXI_awready),
        .awaddr   (AXI_awaddr),
        .wvalid   (AXI_wvalid),
        .wready   (AXI_wready),
        .wdata    (AXI_wdata),
        .wstrb    (AXI_wstrb),
        .bvalid   (AXI_bvalid),
        .bready   (AXI_bready),
        .bresp    (AXI_bresp),
        .cm_valid (cm_valid),
        .cm_idx   (cm_idx),
        .cm_data  (cm_data),
        .cm_strb  (cm_strb),
        .cm_err   (cm_err)
    );

    // Only CTRL, IRQ_STATUS and IRQ_ENABLE accept writes.
    assign cm_err  = !((cm_idx < STAT_LO) || (cm_idx == IRQ_ST) || (cm_idx == IRQ_EN));
    assign cm_mask = strb_mask(cm_strb);
    assign irq_clr = (cm_valid && cm_idx == IRQ_ST) ? (cm_data[N_IRQ-1:0] & cm_mask[N_IRQ-1:0]) : '0;

    // Per-register write strobe; fires even when no byte is enabled.
    always_comb begin
        pulse_d = '0;
        for (int k = 0; k < N_CTRL; k++) begin
            pulse_d[k] = cm_valid && (cm_idx == IDX_W'(k));
        end
    end

    for (genvar k = 0; k < N_CTRL; k++) begin : g_ctrl_out
        assign Ctrl_Regs[32*k +: 32] = ctrl_q[k];
    end

    // Register storage, write pulses, sticky interrupt status and Irq level.
    always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
        if (!AXI_Rstn) begin
            for (int k = 0; k < N_CTRL; k++) ctrl_q[k] <= '0;
            Ctrl_Wr_Pulse <= '0;
            irq_en_q      <= '0;
            irq_stat_q    <= '0;
            Irq           <= 1'b0;
        end else begin
            for (int k = 0; k < N_CTRL; k++) begin
                if (pulse_d[k]) ctrl_q[k] <= (ctrl_q[k] & ~cm_mask) | (cm_data & cm_mask);
            end
            if (cm_valid && cm_idx == IRQ_EN) begin
                irq_en_q <= (irq_en_q & ~cm_mask[N_IRQ-1:0]) | (cm_data[N_IRQ-1:0] & cm_mask[N_IRQ-1:0]);
            end
            Ctrl_Wr_Pulse <= pulse_d;
            // New events override a same-cycle clear.
            irq_stat_q    <= (irq_stat_q & ~irq_clr) | Irq_Events;
            Irq           <= |(irq_stat_q & irq_en_q);
        end
    end

    always_comb begin
        irq_stat_w = '0;
        irq_en_w   = '0;
        irq_stat_w[N_IRQ-1:0] = irq_stat_q;
        irq_en_w[N_IRQ-1:0]   = irq_en_q;
    end

    assign ar_idx      = AXI_araddr[ADDR_W-1:2];
    assign AXI_arready = live && !AXI_rvalid;

    // Read decode; anything not matched is unmapped and returns zero.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b1;
        for (int k = 0; k < N_CTRL; k++) begin
            if (ar_idx == IDX_W'(k)) begin
                rd_data = ctrl_q[k];
                rd_err  = 1'b0;
            end
        end
        for (int k = 0; k < N_STAT; k++) begin
            if (ar_idx == IDX_W'(N_CTRL + k)) begin
                rd_data = Stat_Regs[32*k +: 32];
                rd_err  = 1'b0;
            end
        end
        if (ar_idx == IRQ_ST) begin
            rd_data = irq_stat_w;
            rd_err  = 1'b0;
        end
        if (ar_idx == IRQ_EN) begin
            rd_data = irq_en_w;
            rd_err  = 1'b0;
        end
    end

    // R channel: capture on AR handshake, hold until rready.
    always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
        if (!AXI_Rstn) begin
            AXI_rvalid <= 1'b0;
            AXI_rdata  <= '0;
            AXI_rresp  <= BRESP_OKAY;
        end else if (AXI_arvalid && AXI_arready) begin
            AXI_rvalid <= 1'b1;
            AXI_rdata  <= rd_data;
            AXI_rresp  <= rd_err ? BRESP_SLVERR : BRESP_OKAY;
        end else if (AXI_rvalid && AXI_rready) begin
            AXI_rvalid <= 1'b0;
        end
    end

endmodule

// File: doc/eth_axil_regfile.md
Name: eth_axil_regfile

Overview:
- Parametrised AXI4-Lite slave register file fronting eth_top control/status, driven by the PS M_AXI_0 master.
- Decouples AW and W channels so either may arrive first or together. Supports byte strobes, SLVERR on bad accesses, sticky W1C interrupt status, and a level interrupt output.
- Replaces ad-hoc single-register AXI glue; generalised in register count and interrupt width.

Parameters:
- ADDR_W, 12, AXI address width; word index = addr[ADDR_W-1:2], addr[1:0] ignored.
- N_CTRL, 4, number of 32-bit read/write control registers.
- N_STAT, 4, number of 32-bit read-only status registers.
- N_IRQ, 8, number of interrupt event bits (1..32).
- Constraint: N_CTRL+N_STAT+2 <= 2^(ADDR_W-2); elaboration error otherwise.

Ports:
- AXI_Clk  in  1  sole clock.
- AXI_Rstn  in  1  reset, asynchronous assert, active-low.
- AXI_awvalid / AXI_awready  in/out  1  write-address handshake.
- AXI_awaddr  in  ADDR_W  write address.
- AXI_wvalid / AXI_wready  in/out  1  write-data handshake.
- AXI_wdata  in  32  write data.
- AXI_wstrb  in  4  byte enables.
- AXI_bvalid / AXI_bready  out/in  1  write-response handshake.
- AXI_bresp  out  2  00 OKAY, 10 SLVERR.
- AXI_arvalid / AXI_arready  in/out  1  read-address handshake.
- AXI_araddr  in  ADDR_W  read address.
- AXI_rvalid / AXI_rready  out/in  1  read-data handshake.
- AXI_rdata  out  32  read data.
- AXI_rresp  out  2  read response.
- Ctrl_Regs  out  32*N_CTRL  flattened control registers; reg k = bits [32k+31:32k].
- Ctrl_Wr_Pulse  out  N_CTRL  1-cycle strobe on a committed write to reg k.
- Stat_Regs  in  32*N_STAT  flattened status inputs, sampled at read.
- Irq_Events  in  N_IRQ  event bits, level-sampled every cycle.
- Irq  out  1  registered OR of (IRQ_STATUS & IRQ_ENABLE).

Behaviour:
- Address map (word index):
  - 0..N_CTRL-1: CTRL, read/write.
  - N_CTRL..N_CTRL+N_STAT-1: STAT, read-only.
  - N_CTRL+N_STAT: IRQ_STATUS, W1C.
  - N_CTRL+N_STAT+1: IRQ_ENABLE, read/write.
  - Higher indices are unmapped.
- Reset state (AXI_Rstn low, async): all ready/valid outputs, bresp, rresp, rdata, Ctrl_Regs, Ctrl_Wr_Pulse, IRQ_STATUS, IRQ_ENABLE and Irq are 0.
  - Ready outputs rise on the first clock after reset release.
  - Any transaction in flight when reset asserts is discarded.
- Write path, with states IDLE, COLLECT, RESP:
  - AXI_awready = !aw_held && !bvalid; AXI_wready = !w_held && !bvalid.
  - Each handshake latches address or data/strobe into its holding register. AW-first, W-first and simultaneous arrival are all legal.
  - Once both are held: commit on the next edge, clear both holds, assert AXI_bvalid.
  - Hold AXI_bvalid until AXI_bready. Only one outstanding write.
  - Minimum latency: AW+W handshake at cycle N gives bvalid at N+1.
- Commit rules:
  - CTRL/IRQ_ENABLE: update only the bytes whose wstrb bit is set. Pulse Ctrl_Wr_Pulse[k] for one cycle (cycle N+1) on a CTRL commit, even when wstrb=0. bresp OKAY.
  - IRQ_STATUS: clear bits where wdata=1 and the byte strobe is set. bresp OKAY.
  - STAT or unmapped: no state change, bresp SLVERR.
  - IRQ_ENABLE and IRQ_STATUS bits at or above N_IRQ read as 0 and ignore writes.
- Read path:
  - AXI_arready = !AXI_rvalid.
  - An AR handshake at cycle N registers rdata/rresp and raises rvalid at N+1.
  - rvalid, rdata and rresp stay stable until AXI_rready.
  - Unmapped reads return rdata=0, rresp=SLVERR. STAT reads are OKAY.
- Read/write collision: a read whose AR handshake is in the same cycle as a write commit to the same register returns the pre-write value.
- IRQ_STATUS:
  - Update per cycle: status <= (status & ~clr) | Irq_Events.
  - If set and clear hit the same bit in the same cycle, set wins.
- Irq is registered: it reflects status/enable one cycle after they change.

Decomposition:
- Shared package eth_regs_pkg holds:
  - BRESP_OKAY/BRESP_SLVERR constants.
  - Word-index functions for the STAT base, IRQ_STATUS and IRQ_ENABLE offsets, derived from N_CTRL/N_STAT.
  - A write-FSM state enum.
- One natural sub-module is eth_axil_wr_collect: AW/W holding registers, the commit strobe and the B channel. The read path and register storage stay in the top.

Test Plan:
- AW then W three cycles later: write 0xDEADBEEF to word 1 with wstrb=0xF. Required: bvalid one cycle after the W handshake, bresp=00, Ctrl_Regs[63:32]=0xDEADBEEF, Ctrl_Wr_Pulse=0b0010 for one cycle.
- Byte strobe: with word 0 = 0x11223344, write W-first 0xAABBCCDD with wstrb=0b0101. Required: word 0 reads 0x11BB33DD with rresp=00.
- STAT read/write: Stat_Regs word 0 = 0x00C0FFEE, read word index N_CTRL (byte addr 0x010). Required: rdata=0x00C0FFEE. Write to that address: bresp=10 and no register change.
- Unmapped access (byte addr 0x040, default parameters): read gives rdata=0, rresp=10; write gives bresp=10.
- Interrupt: set IRQ_ENABLE=0x05, pulse Irq_Events=0x01 for one cycle. Required: Irq high from two cycles later.
  - W1C 0x01 commits in the same cycle that Irq_Events bit 0 pulses again: required IRQ_STATUS[0] stays 1 and Irq stays high.
  - A later W1C 0x01 with no event: required Irq low one cycle after the commit.
- Backpressure and reset:
  - Hold bready=0 for 5 cycles after a write. Required: awready=wready=0 and bvalid stable throughout.
  - Assert AXI_Rstn=0 mid-response. Required: bvalid=0 immediately (asynchronous) and all registers 0.
